wbp_reqbuf: RTL and testbench

//  Pipelined-WB request buffer sitting directly upstream of the pipelined-to-classic

---
 rtl/sfifo.sv | 50 +++++
 rtl/wbp_reqbuf.sv | 120 ++++++++++++
 tb/tb_wbp_reqbuf.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sfifo.sv
// Synchronous FIFO with a first-word-fall-through head and a synchronous flush.
// A flush takes priority over a same-cycle write or read.
module sfifo #(
  parameter int unsigned BW     = 8,
  parameter int unsigned LGFLEN = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic          i_wr,
  input  logic [BW-1:0] i_data,
  output logic          o_full,
  input  logic          i_rd,
  output logic [BW-1:0] o_data,
  output logic          o_empty
);

  localparam int unsigned FLEN = 2 ** LGFLEN;

  logic [BW-1:0]   mem [FLEN];
  logic [LGFLEN:0] wr_ptr;
  logic [LGFLEN:0] rd_ptr;
  logic            do_wr;
  logic            do_rd;

  // Extra pointer MSB distinguishes full from empty.
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[LGFLEN] != rd_ptr[LGFLEN])
                && (wr_ptr[LGFLEN-1:0] == rd_ptr[LGFLEN-1:0]);

  assign do_wr = i_wr && !o_full  && !i_flush;
  assign do_rd = i_rd && !o_empty && !i_flush;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (LGFLEN+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (LGFLEN+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr[LGFLEN-1:0]] <= i_data;
  end

  assign o_data = mem[rd_ptr[LGFLEN-1:0]];

endmodule

// File: rtl/wbp_reqbuf.sv
// Pipelined-WB request buffer: queues master requests, replays them to the slave,
// tracks outstanding transactions and registers the ACK/ERR/data return path.
module wbp_reqbuf #(
  parameter int unsigned AW      = 12,
  parameter int unsigned DW      = 32,
  parameter int unsigned LGFIFO  = 2,
  parameter int unsigned LGDEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_mcyc,
  input  logic            i_mstb,
  input  logic            i_mwe,
  input  logic [AW-1:0]   i_maddr,
  input  logic [DW-1:0]   i_mdata,
  input  logic [DW/8-1:0] i_msel,
  output logic            o_mstall,
  output logic            o_mack,
  output logic [DW-1:0]   o_mdata,
  output logic            o_merr,
  output logic            o_scyc,
  output logic            o_sstb,
  output logic            o_swe,
  output logic [AW-1:0]   o_saddr,
  output logic [DW-1:0]   o_sdata,
  output logic [DW/8-1:0] o_ssel,
  input  logic            i_sstall,
  input  logic            i_sack,
  input  logic [DW-1:0]   i_sdata,
  input  logic            i_serr
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned BW = 1 + AW + DW + SW;
  localparam logic [LGDEPTH-1:0] MAX_PEND = '1;

  logic               accept_c;
  logic               pop_c;
  logic               resp_c;
  logic               serr_c;
  logic               flush_c;
  logic               fifo_full;
  logic               fifo_empty;
  logic               abort;
  logic [LGDEPTH-1:0] npending;
  logic [BW-1:0]      head;

  // Stall depends only on local state so the master never sees a comb loop.
  assign o_mstall = fifo_full || (npending == MAX_PEND) || abort;
  assign accept_c = i_mcyc && i_mstb && !o_mstall;
  assign o_sstb   = o_scyc && !fifo_empty;
  assign pop_c    = o_sstb && !i_sstall;
  assign serr_c   = i_mcyc && o_scyc && i_serr && !abort;
  assign flush_c  = !i_mcyc || serr_c;
  assign resp_c   = o_scyc && (i_sack || i_serr) && !abort && (npending != '0);

  sfifo #(
    .BW     (BW),
    .LGFLEN (LGFIFO)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (flush_c),
    .i_wr    (accept_c),
    .i_data  ({i_mwe, i_maddr, i_mdata, i_msel}),
    .o_full  (fifo_full),
    .i_rd    (pop_c),
    .o_data  (head),
    .o_empty (fifo_empty)
  );

  assign {o_swe, o_saddr, o_sdata, o_ssel} = head;

  // Outstanding count covers both queued and issued requests.
  always_ff @(posedge i_clk) begin
    if (i_reset || flush_c) begin
      npending <= '0;
    end else begin
      case ({accept_c, resp_c})
        2'b10:   npending <= npending + LGDEPTH'(1);
        2'b01:   npending <= npending - LGDEPTH'(1);
        default: npending <= npending;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_scyc <= 1'b0;
    end else if (!i_mcyc || i_serr) begin
      o_scyc <= 1'b0;
    end else if (accept_c) begin
      o_scyc <= 1'b1;
    end else if (fifo_empty && (npending == '0)) begin
      o_scyc <= 1'b0;
    end
  end

  // A slave error holds off the master until it ends its cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_mcyc) begin
      abort <= 1'b0;
    end else if (serr_c) begin
      abort <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_mack  <= 1'b0;
      o_merr  <= 1'b0;
      o_mdata <= '0;
    end else begin
      o_mack <= i_mcyc && o_scyc && i_sack && !abort;
      o_merr <= i_mcyc && o_scyc && i_serr && !abort;
      if (i_sack) o_mdata <= i_sdata;
    end
  end

endmodule

// File: tb/tb_wbp_reqbuf.sv
// Directed bench for wbp_reqbuf: a vector table on the default build plus a
// hand sequence on an LGDEPTH=2 build for the outstanding-limit stall.
module tb_wbp_reqbuf;

  logic        i_clk;
  int          checks;
  int          errors;

  // Default-parameter DUT
  logic        i_reset, i_mcyc, i_mstb, i_mwe;
  logic [11:0] i_maddr;
  logic [31:0] i_mdata;
  logic [3:0]  i_msel;
  logic        o_mstall, o_mack, o_merr, o_scyc, o_sstb, o_swe;
  logic [31:0] o_mdata, o_sdata;
  logic [11:0] o_saddr;
  logic [3:0]  o_ssel;
  logic        i_sstall, i_sack, i_serr;
  logic [31:0] i_sdata;

  // LGDEPTH=2 DUT
  logic        b_reset, b_mcyc, b_mstb, b_mwe;
  logic [11:0] b_maddr;
  logic [31:0] b_mdata;
  logic [3:0]  b_msel;
  logic        b_mstall, b_mack, b_merr, b_scyc, b_sstb, b_swe;
  logic [31:0] b_omdata, b_sdata_o;
  logic [11:0] b_saddr;
  logic [3:0]  b_ssel;
  logic        b_sstall, b_sack, b_serr;
  logic [31:0] b_sdata;

  wbp_reqbuf dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_mcyc(i_mcyc), .i_mstb(i_mstb),
    .i_mwe(i_mwe), .i_maddr(i_maddr), .i_mdata(i_mdata), .i_msel(i_msel),
    .o_mstall(o_mstall), .o_mack(o_mack), .o_mdata(o_mdata), .o_merr(o_merr),
    .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe), .o_saddr(o_saddr),
    .o_sdata(o_sdata), .o_ssel(o_ssel), .i_sstall(i_sstall), .i_sack(i_sack),
    .i_sdata(i_sdata), .i_serr(i_serr)
  );

  wbp_reqbuf #(.LGDEPTH(2)) dut2 (
    .i_clk(i_clk), .i_reset(b_reset), .i_mcyc(b_mcyc), .i_mstb(b_mstb),
    .i_mwe(b_mwe), .i_maddr(b_maddr), .i_mdata(b_mdata), .i_msel(b_msel),
    .o_mstall(b_mstall), .o_mack(b_mack), .o_mdata(b_omdata), .o_merr(b_merr),
    .o_scyc(b_scyc), .o_sstb(b_sstb), .o_swe(b_swe), .o_saddr(b_saddr),
    .o_sdata(b_sdata_o), .o_ssel(b_ssel), .i_sstall(b_sstall), .i_sack(b_sack),
    .i_sdata(b_sdata), .i_serr(b_serr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst, mcyc, mstb, mwe;
    logic [11:0] addr;
    logic        sstall, sack;
    logic [31:0] sdata;
    logic        serr;
    logic        e_scyc, e_sstb, e_mstall, e_mack, e_merr;
    logic [31:0] e_mdata;
    logic        c_s;
    logic [11:0] e_saddr;
    logic        e_swe;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] data_of(input logic [11:0] a);
    return (a == 12'h010) ? 32'hDEADBEEF : {20'hC0DE0, a};
  endfunction

  function automatic logic [3:0] sel_of(input logic [11:0] a);
    return ~a[3:0];
  endfunction

  function automatic vec_t mk(
    input logic rst, mcyc, mstb, mwe, input logic [11:0] addr,
    input logic sstall, sack, input logic [31:0] sdata, input logic serr,
    input logic scyc, sstb, mstall, mack, merr, input logic [31:0] mdata,
    input logic cs, input logic [11:0] saddr, input logic swe);
    vec_t v;
    v.rst = rst; v.mcyc = mcyc; v.mstb = mstb; v.mwe = mwe; v.addr = addr;
    v.sstall = sstall; v.sack = sack; v.sdata = sdata; v.serr = serr;
    v.e_scyc = scyc; v.e_sstb = sstb; v.e_mstall = mstall; v.e_mack = mack;
    v.e_merr = merr; v.e_mdata = mdata; v.c_s = cs; v.e_saddr = saddr; v.e_swe = swe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply(input int idx, input vec_t v);
    i_reset  = v.rst;   i_mcyc = v.mcyc; i_mstb = v.mstb; i_mwe = v.mwe;
    i_maddr  = v.addr;  i_mdata = data_of(v.addr); i_msel = sel_of(v.addr);
    i_sstall = v.sstall; i_sack = v.sack; i_sdata = v.sdata; i_serr = v.serr;
    step();
    chk($sformatf("row%0d scyc", idx),   32'(o_scyc),   32'(v.e_scyc));
    chk($sformatf("row%0d sstb", idx),   32'(o_sstb),   32'(v.e_sstb));
    chk($sformatf("row%0d mstall", idx), 32'(o_mstall), 32'(v.e_mstall));
    chk($sformatf("row%0d mack", idx),   32'(o_mack),   32'(v.e_mack));
    chk($sformatf("row%0d merr", idx),   32'(o_merr),   32'(v.e_merr));
    chk($sformatf("row%0d mdata", idx),  o_mdata,       v.e_mdata);
    if (v.c_s) begin
      chk($sformatf("row%0d saddr", idx), 32'(o_saddr), 32'(v.e_saddr));
      chk($sformatf("row%0d swe", idx),   32'(o_swe),   32'(v.e_swe));
      chk($sformatf("row%0d sdata", idx), o_sdata,      data_of(v.e_saddr));
      chk($sformatf("row%0d ssel", idx),  32'(o_ssel),  32'(sel_of(v.e_saddr)));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i_reset = 1'b1; i_mcyc = 1'b0; i_mstb = 1'b0; i_mwe = 1'b0; i_maddr = '0;
    i_mdata = '0; i_msel = '0; i_sstall = 1'b0; i_sack = 1'b0; i_sdata = '0; i_serr = 1'b0;
    b_reset = 1'b1; b_mcyc = 1'b0; b_mstb = 1'b0; b_mwe = 1'b0; b_maddr = '0;
    b_mdata = '0; b_msel = '0; b_sstall = 1'b0; b_sack = 1'b0; b_sdata = '0; b_serr = 1'b0;

    // reset
    vecs.push_back(mk(1,0,0,0,12'h000,0,0,32'h0,0, 0,0,0,0,0,32'h0, 0,12'h000,0));
    // single write, ack one cycle after STB
    vecs.push_back(mk(0,1,1,1,12'h010,0,0,32'h0,0, 1,1,0,0,0,32'h0, 1,12'h010,1));
    vecs.push_back(mk(0,1,0,0,12'h000,0,0,32'h0,0, 1,0,0,0,0,32'h0, 0,12'h000,0));
    vecs.push_back(mk(0,1,0,0,12'h000,0,1,32'h77,0, 1,0,0,1,0,32'h77, 0,12'h000,0));
    vecs.push_back(mk(0,1,0,0,12'h000,0,0,32'h0,0, 0,0,0,0,0,32'h77, 0,12'h000,0));
    vecs.push_back(mk(0,0,0,0,12'h000,0,0,32'h0,0, 0,0,0,0,0,32'h77, 0,12'h000,0));
    // four reads under stall, fifth refused, in-order acks
    vecs.push_back(mk(0,1,1,0,12'h100,1,0,32'h0,0, 1,1,0,0,0,32'h77, 1,12'h100,0));
    vecs.push_back(mk(0,1,1,0,12'h101,1,0,32'h0,0, 1,1,0,0,0,32'h77, 1,12'h100,0));
    vecs.push_back(mk(0,1,1,0,12'h102,1,0,32'h0,0, 1,1,0,0,0,32'h77, 1,12'h100,0));
    vecs.push_back(mk(0,1,1,0,12'h103,1,0,32'h0,0, 1,1,1,0,0,32'h77, 1,12'h100,0));
    vecs.push_back(mk(0,1,1,0,12'h104,1,0,32'h0,0, 1,1,1,0,0,32'h77, 1,12'h100,0));
    vecs.push_back(mk(0,1,0,0,12'h000,0,0,32'h0,0, 1,1,0,0,0,32'h77, 1,12'h101,0));
    vecs.push_back(mk(0,1,0,0,12'h000,0,1,32'h1,0, 1,1,0,1,0,32'h1, 1,12'h102,0));
    vecs.push_back(mk(0,1,0,0,12'h000,0,1,32'h2,0, 1,1,0,1,0,32'h2, 1,12'h103,0));
    vecs.push_back(mk(0,1,0,0,12'h000,0,1,32'h3,0, 1,0,0,1,0,32'h3, 0,12'h000,0));
    vecs.push_back(mk(0,1,0,0,12'h000,0,1,32'h4,0, 1,0,0,1,0,32'h4, 0,12'h000,0));
    vecs.push_back(mk(0,1,0,0,12'h000,0,0,32'h0,0, 0,0,0,0,0,32'h4, 0,12'h000,0));
    vecs.push_back(mk(0,0,0,0,12'h000,0,0,32'h0,0, 0,0,0,0,0,32'h4, 0,12'h000,0));
    // slave error on first of two queued reads
    vecs.push_back(mk(0,1,1,0,12'h200,1,0,32'h0,0, 1,1,0,0,0,32'h4, 1,12'h200,0));
    vecs.push_back(mk(0,1,1,0,12'h201,1,0,32'h0,0, 1,1,0,0,0,32'h4, 1,12'h200,0));
    vecs.push_back(mk(0,1,0,0,12'h000,0,0,32'h0,0, 1,1,0,0,0,32'h4, 1,12'h201,0));
    vecs.push_back(mk(0,1,0,0,12'h000,1,0,32'h0,1, 0,0,1,0,1,32'h4, 0,12'h000,0));
    vecs.push_back(mk(0,1,0,0,12'h000,0,1,32'h4,0, 0,0,1,0,0,32'h4, 0,12'h000,0));
    vecs.push_back(mk(0,1,0,0,12'h000,0,0,32'h0,1, 0,0,1,0,0,32'h4, 0,12'h000,0));
    vecs.push_back(mk(0,1,1,0,12'h2FF,0,0,32'h0,0, 0,0,1,0,0,32'h4, 0,12'h000,0));
    vecs.push_back(mk(0,0,0,0,12'h000,0,0,32'h0,0, 0,0,0,0,0,32'h4, 0,12'h000,0));
    // master drops CYC with three queued
    vecs.push_back(mk(0,1,1,0,12'h300,1,0,32'h0,0, 1,1,0,0,0,32'h4, 1,12'h300,0));
    vecs.push_back(mk(0,1,1,0,12'h301,1,0,32'h0,0, 1,1,0,0,0,32'h4, 1,12'h300,0));
    vecs.push_back(mk(0,1,1,0,12'h302,1,0,32'h0,0, 1,1,0,0,0,32'h4, 1,12'h300,0));
    vecs.push_back(mk(0,0,0,0,12'h000,1,1,32'h4,0, 0,0,0,0,0,32'h4, 0,12'h000,0));
    vecs.push_back(mk(0,1,0,0,12'h000,0,0,32'h0,0, 0,0,0,0,0,32'h4, 0,12'h000,0));
    vecs.push_back(mk(0,1,1,0,12'h3A0,1,0,32'h0,0, 1,1,0,0,0,32'h4, 1,12'h3A0,0));
    vecs.push_back(mk(0,0,0,0,12'h000,0,0,32'h0,0, 0,0,0,0,0,32'h4, 0,12'h000,0));
    // reset mid-burst
    vecs.push_back(mk(0,1,1,0,12'h400,1,0,32'h0,0, 1,1,0,0,0,32'h4, 1,12'h400,0));
    vecs.push_back(mk(0,1,1,0,12'h401,1,1,32'h9,0, 1,1,0,1,0,32'h9, 1,12'h400,0));
    vecs.push_back(mk(1,1,1,0,12'h402,1,1,32'h55,0, 0,0,0,0,0,32'h0, 0,12'h000,0));
    vecs.push_back(mk(0,1,0,0,12'h000,0,0,32'h0,0, 0,0,0,0,0,32'h0, 0,12'h000,0));
    vecs.push_back(mk(0,1,1,1,12'h403,1,0,32'h0,0, 1,1,0,0,0,32'h0, 1,12'h403,1));
    vecs.push_back(mk(0,0,0,0,12'h000,0,0,32'h0,0, 0,0,0,0,0,32'h0, 0,12'h000,0));

    step();
    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // LGDEPTH=2: stall on three outstanding while the FIFO is empty
    b_reset = 1'b0;
    b_mcyc = 1'b1; b_mstb = 1'b1; b_maddr = 12'h010;
    step();
    chk("d2 acc0 mstall", 32'(b_mstall), 32'd0);
    chk("d2 acc0 saddr",  32'(b_saddr),  32'h010);
    b_maddr = 12'h011;
    step();
    chk("d2 acc1 mstall", 32'(b_mstall), 32'd0);
    chk("d2 acc1 saddr",  32'(b_saddr),  32'h011);
    b_maddr = 12'h012;
    step();
    chk("d2 acc2 mstall", 32'(b_mstall), 32'd1);
    chk("d2 acc2 sstb",   32'(b_sstb),   32'd1);
    b_maddr = 12'h013;
    for (int k = 0; k < 9; k++) begin
      step();
      chk($sformatf("d2 wait%0d mstall", k), 32'(b_mstall), 32'd1);
      chk($sformatf("d2 wait%0d sstb", k),   32'(b_sstb),   32'd0);
      chk($sformatf("d2 wait%0d scyc", k),   32'(b_scyc),   32'd1);
    end
    b_mstb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b_sack = 1'b1; b_sdata = 32'(k + 16);
      step();
      chk($sformatf("d2 ack%0d mack", k),   32'(b_mack),   32'd1);
      chk($sformatf("d2 ack%0d mdata", k),  b_omdata,      32'(k + 16));
      chk($sformatf("d2 ack%0d mstall", k), 32'(b_mstall), 32'd0);
    end
    b_sack = 1'b0;
    step();
    chk("d2 idle scyc", 32'(b_scyc), 32'd0);
    chk("d2 idle mack", 32'(b_mack), 32'd0);
    b_mcyc = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
